// File: rtl/regfile_mp_pkg.sv
// regfile_mp_pkg: shared types and architectural constants for the multi-port register file.
//   op_t       32-bit operand type used by the DATA_W=32 instance
//   GPAt/SPAt  reset values of the global and stack pointer registers
//   RF_GP_IDX  index of the global pointer register
//   RF_SP_IDX  index of the stack pointer register
package regfile_mp_pkg;
   typedef logic [31:0] op_t;
   localparam op_t GPAt      = 32'h1000_8000;
   localparam op_t SPAt      = 32'h7fff_effc;
   localparam int  RF_GP_IDX = 28;
   localparam int  RF_SP_IDX = 29;
endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: read/write port bundle between the pipeline and the register file.
//   master  drives read/write requests and receives rd_data and wr_conflict
//   slave   the register file side
interface regfile_mp_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2,
   parameter int NUM_WR = 1
);
   logic [NUM_RD-1:0]             rd_en;
   logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr;
   logic [NUM_RD-1:0][DATA_W-1:0] rd_data;
   logic [NUM_WR-1:0]             wr_en;
   logic [NUM_WR-1:0][ADDR_W-1:0] wr_addr;
   logic [NUM_WR-1:0][DATA_W-1:0] wr_data;
   logic                          wr_conflict;
   modport master (
      output rd_en, rd_addr, wr_en, wr_addr, wr_data,
      input  rd_data, wr_conflict
   );
   modport slave (
      input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
      output rd_data, wr_conflict
   );
endinterface

// File: rtl/regfile_mp_bypass_sel.sv
// regfile_bypass_sel: combinational read-value resolution for one read port.
//   rd_addr_i  read index
//   wr_en_i    write enables of all write ports
//   wr_addr_i  write indices of all write ports
//   wr_data_i  write data of all write ports
//   regs_i     pre-edge register array contents
//   val_o      resolved read value
module regfile_bypass_sel
   import regfile_mp_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int DEPTH    = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_WR   = 1,
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS   = 1'b1
) (
   input  logic [ADDR_W-1:0]             rd_addr_i,
   input  logic [NUM_WR-1:0]             wr_en_i,
   input  logic [NUM_WR-1:0][ADDR_W-1:0] wr_addr_i,
   input  logic [NUM_WR-1:0][DATA_W-1:0] wr_data_i,
   input  logic [DEPTH-1:0][DATA_W-1:0]  regs_i,
   output logic [DATA_W-1:0]             val_o
);
   typedef logic [ADDR_W-1:0] rf_addr_t;
   rf_addr_t addr;
   assign addr = rd_addr_i;
   // Later assignments take priority: array, then bypass (highest port last), then zero register.
   always_comb begin
      val_o = regs_i[addr];
      for (int w = 0; w < NUM_WR; w++)
         if (BYPASS && wr_en_i[w] && wr_addr_i[w] == addr) val_o = wr_data_i[w];
      if (ZERO_REG && addr == '0) val_o = '0;
   end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with zero register, write bypass,
// per-port read hold and write-conflict detection.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; array to init values, outputs to 0
//   rf     slave side of regfile_mp_if (read/write ports, rd_data, wr_conflict)
module regfile_mp
   import regfile_mp_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int DEPTH    = 32,
   parameter int NUM_RD   = 2,
   parameter int NUM_WR   = 1,
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS   = 1'b1
) (
   input logic         clk,
   input logic         rst_n,
   regfile_mp_if.slave rf
);
   localparam int ADDR_W = $clog2(DEPTH);
   typedef logic [ADDR_W-1:0]             rf_addr_t;
   typedef logic [DEPTH-1:0][DATA_W-1:0]  rf_arr_t;
   rf_arr_t                       regs_q, regs_d;
   logic [NUM_RD-1:0][DATA_W-1:0] rd_val, rd_data_q;
   logic                          wr_conflict_q, wr_conflict_d;
   // GP/SP init values only exist when the array is deep enough to hold them.
   function automatic rf_arr_t init_regs();
      rf_arr_t r;
      for (int i = 0; i < DEPTH; i++)
         r[i] = (DEPTH > 29 && i == RF_GP_IDX) ? DATA_W'(GPAt) :
                (DEPTH > 29 && i == RF_SP_IDX) ? DATA_W'(SPAt) : '0;
      return r;
   endfunction
   function automatic logic writable(rf_addr_t a);
      return !(ZERO_REG && a == '0);
   endfunction
   // Ports applied in index order so the highest-index port wins on a shared address.
   always_comb begin
      regs_d = regs_q;
      for (int w = 0; w < NUM_WR; w++)
         if (rf.wr_en[w] && writable(rf.wr_addr[w])) regs_d[rf.wr_addr[w]] = rf.wr_data[w];
   end
   always_comb begin
      wr_conflict_d = 1'b0;
      for (int a = 0; a < NUM_WR; a++)
         for (int b = a + 1; b < NUM_WR; b++)
            if (rf.wr_en[a] && rf.wr_en[b] && rf.wr_addr[a] == rf.wr_addr[b] && writable(rf.wr_addr[a]))
               wr_conflict_d = 1'b1;
   end
   for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
      regfile_bypass_sel #(
         .DATA_W  (DATA_W),
         .DEPTH   (DEPTH),
         .ADDR_W  (ADDR_W),
         .NUM_WR  (NUM_WR),
         .ZERO_REG(ZERO_REG),
         .BYPASS  (BYPASS)
      ) u_sel (
         .rd_addr_i(rf.rd_addr[r]),
         .wr_en_i  (rf.wr_en),
         .wr_addr_i(rf.wr_addr),
         .wr_data_i(rf.wr_data),
         .regs_i   (regs_q),
         .val_o    (rd_val[r])
      );
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regs_q        <= init_regs();
         rd_data_q     <= '0;
         wr_conflict_q <= 1'b0;
      end else begin
         regs_q        <= regs_d;
         wr_conflict_q <= wr_conflict_d;
         for (int r = 0; r < NUM_RD; r++)
            if (rf.rd_en[r]) rd_data_q[r] <= rd_val[r];
      end
   end
   assign rf.rd_data     = rd_data_q;
   assign rf.wr_conflict = wr_conflict_q;
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed checks of two register file configurations sharing clock and reset.
//   a: 3 read ports, 2 write ports, bypass on
//   b: 1 read port, 1 write port, bypass off
module tb_regfile_mp;
   import regfile_mp_pkg::*;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;
   always #5 clk = ~clk;
   regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(3), .NUM_WR(2)) a_if ();
   regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(1), .NUM_WR(1)) b_if ();
   regfile_mp #(.NUM_RD(3), .NUM_WR(2), .BYPASS(1'b1)) dut_a (.clk(clk), .rst_n(rst_n), .rf(a_if));
   regfile_mp #(.NUM_RD(1), .NUM_WR(1), .BYPASS(1'b0)) dut_b (.clk(clk), .rst_n(rst_n), .rf(b_if));
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic idle();
      a_if.rd_en = '0; a_if.wr_en = '0;
      b_if.rd_en = '0; b_if.wr_en = '0;
   endtask
   initial begin
      idle();
      a_if.rd_addr = '0; a_if.wr_addr = '0; a_if.wr_data = '0;
      b_if.rd_addr = '0; b_if.wr_addr = '0; b_if.wr_data = '0;
      #2;
      chk("rst_a_rd0", a_if.rd_data[0], 32'h0);
      chk("rst_a_conf", {31'b0, a_if.wr_conflict}, 32'h0);
      chk("rst_b_rd0", b_if.rd_data[0], 32'h0);
      step();
      a_if.rd_en = 3'b111;
      a_if.rd_addr[0] = 5'd28; a_if.rd_addr[1] = 5'd29; a_if.rd_addr[2] = 5'd5;
      b_if.rd_en = 1'b1; b_if.rd_addr[0] = 5'd29;
      rst_n = 1'b1;
      step();
      chk("init_gp", a_if.rd_data[0], GPAt);
      chk("init_sp", a_if.rd_data[1], SPAt);
      chk("init_r5", a_if.rd_data[2], 32'h0);
      chk("init_b_sp", b_if.rd_data[0], SPAt);
      idle();
      a_if.wr_en = 2'b01; a_if.wr_addr[0] = 5'd7; a_if.wr_data[0] = 32'hdeadbeef;
      b_if.wr_en = 1'b1; b_if.wr_addr[0] = 5'd7; b_if.wr_data[0] = 32'hdeadbeef;
      step();
      idle();
      a_if.rd_en = 3'b001; a_if.rd_addr[0] = 5'd7;
      b_if.rd_en = 1'b1; b_if.rd_addr[0] = 5'd7;
      step();
      chk("wr_rd_a", a_if.rd_data[0], 32'hdeadbeef);
      chk("wr_rd_b", b_if.rd_data[0], 32'hdeadbeef);
      a_if.wr_en = 2'b01; a_if.wr_data[0] = 32'h12345678;
      b_if.wr_en = 1'b1; b_if.wr_data[0] = 32'h12345678;
      step();
      chk("bypass_on", a_if.rd_data[0], 32'h12345678);
      chk("bypass_off", b_if.rd_data[0], 32'hdeadbeef);
      a_if.wr_en = '0; b_if.wr_en = '0;
      step();
      chk("bypass_off_next", b_if.rd_data[0], 32'h12345678);
      idle();
      a_if.wr_en = 2'b11;
      a_if.wr_addr[0] = 5'd0; a_if.wr_data[0] = 32'hffffffff;
      a_if.wr_addr[1] = 5'd0; a_if.wr_data[1] = 32'hb;
      a_if.rd_en = 3'b001; a_if.rd_addr[0] = 5'd0;
      step();
      chk("zero_same_cyc", a_if.rd_data[0], 32'h0);
      chk("zero_no_conf", {31'b0, a_if.wr_conflict}, 32'h0);
      a_if.wr_en = '0;
      step();
      chk("zero_after", a_if.rd_data[0], 32'h0);
      a_if.wr_en = 2'b11;
      a_if.wr_addr[0] = 5'd3; a_if.wr_data[0] = 32'ha;
      a_if.wr_addr[1] = 5'd3; a_if.wr_data[1] = 32'hb;
      a_if.rd_en = 3'b010; a_if.rd_addr[1] = 5'd3;
      step();
      chk("coll_pulse", {31'b0, a_if.wr_conflict}, 32'h1);
      chk("coll_bypass_tie", a_if.rd_data[1], 32'hb);
      a_if.wr_en = '0;
      a_if.rd_en = 3'b001; a_if.rd_addr[0] = 5'd3;
      step();
      chk("coll_pulse_end", {31'b0, a_if.wr_conflict}, 32'h0);
      chk("coll_winner", a_if.rd_data[0], 32'hb);
      idle();
      a_if.wr_en = 2'b11;
      a_if.wr_addr[0] = 5'd4; a_if.wr_data[0] = 32'h55;
      a_if.wr_addr[1] = 5'd9; a_if.wr_data[1] = 32'h99;
      step();
      chk("diff_addr_no_conf", {31'b0, a_if.wr_conflict}, 32'h0);
      a_if.wr_en = '0;
      a_if.rd_en = 3'b001; a_if.rd_addr[0] = 5'd4;
      step();
      chk("hold_load", a_if.rd_data[0], 32'h55);
      a_if.rd_en = '0; a_if.rd_addr[0] = 5'd9;
      a_if.wr_en = 2'b01; a_if.wr_addr[0] = 5'd4; a_if.wr_data[0] = 32'h66;
      step();
      chk("hold_1", a_if.rd_data[0], 32'h55);
      a_if.wr_en = '0;
      step();
      chk("hold_2", a_if.rd_data[0], 32'h55);
      a_if.rd_en = 3'b001;
      step();
      chk("hold_release", a_if.rd_data[0], 32'h99);
      a_if.wr_en = 2'b01; a_if.wr_addr[0] = 5'd10; a_if.wr_data[0] = 32'h77;
      a_if.rd_en = 3'b001; a_if.rd_addr[0] = 5'd4;
      #1;
      rst_n = 1'b0;
      #1;
      chk("async_rst_rd", a_if.rd_data[0], 32'h0);
      chk("async_rst_b", b_if.rd_data[0], 32'h0);
      step();
      chk("rst_held_rd", a_if.rd_data[0], 32'h0);
      idle();
      a_if.rd_en = 3'b111;
      a_if.rd_addr[0] = 5'd10; a_if.rd_addr[1] = 5'd7; a_if.rd_addr[2] = 5'd28;
      rst_n = 1'b1;
      step();
      chk("midrst_r10", a_if.rd_data[0], 32'h0);
      chk("midrst_r7", a_if.rd_data[1], 32'h0);
      chk("midrst_gp", a_if.rd_data[2], GPAt);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
